// File: rtl/frame_pixel_tracker.sv
// Pixel/line/frame position tracker for a camera capture path: tags each valid pixel with x/y and SOF/EOL/EOF, flags size errors.
// Latency 1 cycle, no backpressure. Optional idle-frame timeout under macro FRAME_TIMEOUT_EN.
module frame_pixel_tracker #(
  parameter int IMAGE_WIDTH  = 384,
  parameter int IMAGE_HEIGHT = 288,
  parameter int TIMEOUT_CYC  = 1048575
) (
  input  logic        i_Sys_clk,
  input  logic        i_Rst_n,
  input  logic        i_Frame_start,
  input  logic        i_Line_start,
  input  logic        i_Din_valid,
  input  logic [15:0] i_Din,
  output logic [15:0] o_Dout,
  output logic        o_Dout_valid,
  output logic [11:0] o_Pix_x,
  output logic [11:0] o_Line_y,
  output logic        o_Sof,
  output logic        o_Eol,
  output logic        o_Eof,
  output logic [15:0] o_Frame_cnt,
  output logic        o_Size_err,
  output logic        o_Busy
);

  localparam logic [11:0] LAST_X = 12'(IMAGE_WIDTH - 1);
  localparam logic [11:0] LAST_Y = 12'(IMAGE_HEIGHT - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic        w_pix, w_last_x, w_done, w_err_nxt;

`ifdef FRAME_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);
  logic [19:0] r_tmo, w_tmo_nxt;
`endif

  assign w_pix    = (r_state == ACTIVE) && i_Din_valid;
  assign w_last_x = (r_x == LAST_X);
  assign w_done   = w_pix && w_last_x && (r_y == LAST_Y);
  assign o_Busy   = (r_state == ACTIVE);

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_err_nxt   = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    w_tmo_nxt   = '0;
`endif
    case (r_state)
      IDLE: begin
        if (i_Frame_start) begin
          w_state_nxt = ACTIVE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (w_pix) begin
          if (w_last_x) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + 12'd1;
          end else begin
            w_x_nxt = r_x + 12'd1;
          end
        end
        if (w_done) begin
          w_state_nxt = IDLE;
          w_y_nxt     = '0;
        end
        // The pixel is accounted first; a frame start on the final pixel is a clean handover.
        if (i_Frame_start) begin
          w_err_nxt   = !w_done;
          w_state_nxt = ACTIVE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else if (i_Line_start && (w_x_nxt != 12'd0)) begin
          w_err_nxt = 1'b1;
          w_x_nxt   = '0;
          w_y_nxt   = w_y_nxt + 12'd1;
        end
`ifdef FRAME_TIMEOUT_EN
        if (!w_pix && !i_Frame_start) begin
          if (r_tmo == TMO_LAST) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_tmo_nxt = r_tmo + 20'd1;
          end
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      o_Dout       <= '0;
      o_Dout_valid <= 1'b0;
      o_Pix_x      <= '0;
      o_Line_y     <= '0;
      o_Sof        <= 1'b0;
      o_Eol        <= 1'b0;
      o_Eof        <= 1'b0;
      o_Frame_cnt  <= '0;
      o_Size_err   <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_tmo        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      o_Size_err   <= w_err_nxt;
      o_Dout_valid <= w_pix;
      o_Sof        <= w_pix && (r_x == 12'd0) && (r_y == 12'd0);
      o_Eol        <= w_pix && w_last_x;
      o_Eof        <= w_done;
      if (w_pix) begin
        o_Dout   <= i_Din;
        o_Pix_x  <= r_x;
        o_Line_y <= r_y;
      end
      if (w_done) o_Frame_cnt <= o_Frame_cnt + 16'd1;
`ifdef FRAME_TIMEOUT_EN
      r_tmo        <= w_tmo_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_frame_pixel_tracker.sv
// Bench for frame_pixel_tracker: directed scenarios plus randomized traffic against a linear-position reference model.
module tb_frame_pixel_tracker;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int TMO = 16;

  logic        i_Sys_clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Frame_start = 1'b0, i_Line_start = 1'b0, i_Din_valid = 1'b0;
  logic [15:0] i_Din = '0;
  logic [15:0] o_Dout, o_Frame_cnt;
  logic        o_Dout_valid, o_Sof, o_Eol, o_Eof, o_Size_err, o_Busy;
  logic [11:0] o_Pix_x, o_Line_y;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is a linear pixel index; short lines jump to the next multiple of W.
  bit          m_active;
  int          m_pos, m_idle;
  logic [15:0] m_cnt;
  logic        e_vld, e_sof, e_eol, e_eof, e_err;
  logic [15:0] e_dout;
  logic [11:0] e_x, e_y;

  frame_pixel_tracker #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .TIMEOUT_CYC(TMO)) dut (
    .i_Sys_clk(i_Sys_clk), .i_Rst_n(i_Rst_n), .i_Frame_start(i_Frame_start),
    .i_Line_start(i_Line_start), .i_Din_valid(i_Din_valid), .i_Din(i_Din),
    .o_Dout(o_Dout), .o_Dout_valid(o_Dout_valid), .o_Pix_x(o_Pix_x), .o_Line_y(o_Line_y),
    .o_Sof(o_Sof), .o_Eol(o_Eol), .o_Eof(o_Eof), .o_Frame_cnt(o_Frame_cnt),
    .o_Size_err(o_Size_err), .o_Busy(o_Busy)
  );

  always #5 i_Sys_clk = ~i_Sys_clk;

  task automatic do_reset(input int cycles);
    i_Rst_n = 1'b0;
    i_Frame_start = 1'b1; i_Line_start = 1'b1; i_Din_valid = 1'b1; i_Din = 16'hBEEF;
    repeat (cycles) @(posedge i_Sys_clk);
    #1;
    i_Rst_n = 1'b1;
    i_Frame_start = 1'b0; i_Line_start = 1'b0; i_Din_valid = 1'b0; i_Din = '0;
    m_active = 0; m_pos = 0; m_idle = 0; m_cnt = '0;
    e_vld = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
    e_dout = '0; e_x = '0; e_y = '0;
  endtask

  // Drive one cycle, advance the model, return #1 after the edge.
  task automatic drive(input bit fs, input bit ls, input bit v, input logic [15:0] d);
    bit was, pix, done;
    i_Frame_start = fs; i_Line_start = ls; i_Din_valid = v; i_Din = d;
    was = m_active;
    pix = was && v;
    done = 0;
    e_vld = pix; e_sof = 0; e_eol = 0; e_eof = 0; e_err = 0;
    if (pix) begin
      e_dout = d;
      e_x = 12'(m_pos % W);
      e_y = 12'(m_pos / W);
      e_sof = (m_pos == 0);
      e_eol = (m_pos % W == W - 1);
      done = (m_pos == W * H - 1);
      e_eof = done;
      m_pos++;
      if (done) begin
        m_cnt++;
        m_active = 0;
        m_pos = 0;
      end
    end
    if (fs) begin
      if (was && !done) e_err = 1;
      m_active = 1;
      m_pos = 0;
    end else if (m_active && ls && (m_pos % W != 0)) begin
      e_err = 1;
      m_pos = (m_pos / W + 1) * W;
    end
`ifdef FRAME_TIMEOUT_EN
    if (was && !pix && !fs) begin
      m_idle++;
      if (m_idle == TMO) begin
        e_err = 1;
        m_active = 0;
        m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
`endif
    @(posedge i_Sys_clk);
    #1;
    i_Frame_start = 0; i_Line_start = 0; i_Din_valid = 0;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if ({o_Dout, o_Dout_valid, o_Pix_x, o_Line_y, o_Sof, o_Eol, o_Eof, o_Frame_cnt, o_Size_err, o_Busy} !== 62'd0) begin
      n_fail++;
      $display("FAIL reset_state: got dout=%h vld=%b x=%0d y=%0d sof=%b eol=%b eof=%b cnt=%0d err=%b busy=%b, want all 0",
               o_Dout, o_Dout_valid, o_Pix_x, o_Line_y, o_Sof, o_Eol, o_Eof, o_Frame_cnt, o_Size_err, o_Busy);
    end
  endtask

  task automatic test_basic_frame();
    do_reset(2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 16'(i + 1));
      n_tests++;
      if ({o_Dout_valid, o_Dout, o_Pix_x, o_Line_y, o_Sof, o_Eol, o_Eof, o_Size_err} !==
          {1'b1, 16'(i + 1), 12'(i % 4), 12'(i / 4), (i == 0), (i == 3 || i == 7), (i == 7), 1'b0}) begin
        n_fail++;
        $display("FAIL basic_pixel%0d: got vld=%b dout=%0d x=%0d y=%0d sof=%b eol=%b eof=%b err=%b, want 1 %0d %0d %0d %b %b %b 0",
                 i, o_Dout_valid, o_Dout, o_Pix_x, o_Line_y, o_Sof, o_Eol, o_Eof, o_Size_err,
                 i + 1, i % 4, i / 4, i == 0, i == 3 || i == 7, i == 7);
      end
    end
    n_tests++;
    if (o_Frame_cnt !== 16'd1 || o_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got cnt=%0d busy=%b, want cnt=1 busy=0", o_Frame_cnt, o_Busy);
    end
    drive(0, 0, 0, 0);
    n_tests++;
    if (o_Dout_valid !== 1'b0 || o_Dout !== 16'd8) begin
      n_fail++;
      $display("FAIL dout_hold: got vld=%b dout=%0d, want vld=0 dout=8", o_Dout_valid, o_Dout);
    end
  endtask

  task automatic test_no_frame();
    int seen = 0;
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      drive(0, i[0], 1, 16'(100 + i));
      if (o_Dout_valid !== 1'b0 || o_Busy !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0 || o_Frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_ignore: got %0d active cycles cnt=%0d, want 0 and 0", seen, o_Frame_cnt);
    end
  endtask

  task automatic test_short_line();
    int errs = 0;
    do_reset(2);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 16'h11); errs += int'(o_Size_err);
    drive(0, 0, 1, 16'h12); errs += int'(o_Size_err);
    drive(0, 1, 0, 0);
    n_tests++;
    if (o_Size_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_line_err: got err=%b, want 1", o_Size_err);
    end
    errs += int'(o_Size_err);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 16'(i));
      errs += int'(o_Size_err);
      if (i == 0) begin
        n_tests++;
        if (o_Pix_x !== 12'd0 || o_Line_y !== 12'd1 || o_Dout_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL short_line_next: got vld=%b x=%0d y=%0d, want 1 0 1", o_Dout_valid, o_Pix_x, o_Line_y);
        end
      end
    end
    n_tests++;
    if (errs != 1) begin
      n_fail++;
      $display("FAIL short_line_pulses: got %0d, want 1", errs);
    end
  endtask

  task automatic test_early_frame();
    do_reset(2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 16'(i));
    drive(1, 0, 0, 0);
    n_tests++;
    if (o_Size_err !== 1'b1 || o_Frame_cnt !== 16'd0 || o_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_frame: got err=%b cnt=%0d busy=%b, want 1 0 1", o_Size_err, o_Frame_cnt, o_Busy);
    end
    drive(0, 0, 1, 16'h55);
    n_tests++;
    if (o_Sof !== 1'b1 || o_Pix_x !== 12'd0 || o_Line_y !== 12'd0 || o_Size_err !== 1'b0) begin
      n_fail++;
      $display("FAIL early_restart: got sof=%b x=%0d y=%0d err=%b, want 1 0 0 0", o_Sof, o_Pix_x, o_Line_y, o_Size_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 16'(i));
    drive(1, 0, 1, 16'h77);
    n_tests++;
    if (o_Eof !== 1'b1 || o_Frame_cnt !== 16'd1 || o_Size_err !== 1'b0 || o_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_final: got eof=%b cnt=%0d err=%b busy=%b, want 1 1 0 1", o_Eof, o_Frame_cnt, o_Size_err, o_Busy);
    end
    drive(0, 0, 1, 16'h78);
    n_tests++;
    if (o_Sof !== 1'b1 || o_Pix_x !== 12'd0 || o_Line_y !== 12'd0) begin
      n_fail++;
      $display("FAIL b2b_next: got sof=%b x=%0d y=%0d, want 1 0 0", o_Sof, o_Pix_x, o_Line_y);
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    do_reset(2);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'(i));
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 16'(i));
      if (o_Eof !== 1'b0 || o_Size_err !== 1'b0 || o_Dout_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || o_Busy !== 1'b0 || o_Frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d bad cycles busy=%b cnt=%0d, want 0 0 0", bad, o_Busy, o_Frame_cnt);
    end
  endtask

  task automatic test_timeout();
    int errs = 0;
    do_reset(2);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 16'h1);
    for (int i = 0; i < TMO; i++) begin
      drive(0, 0, 0, 0);
      errs += int'(o_Size_err);
    end
`ifdef FRAME_TIMEOUT_EN
    n_tests++;
    if (o_Size_err !== 1'b1 || o_Busy !== 1'b0 || errs != 1) begin
      n_fail++;
      $display("FAIL timeout: got err=%b busy=%b pulses=%0d, want 1 0 1", o_Size_err, o_Busy, errs);
    end
`else
    repeat (8) drive(0, 0, 0, 0);
    n_tests++;
    if (o_Busy !== 1'b1 || errs != 0) begin
      n_fail++;
      $display("FAIL no_timeout: got busy=%b pulses=%0d, want 1 0", o_Busy, errs);
    end
`endif
  endtask

  task automatic test_random();
    bit fs, ls, v;
    int bad = 0;
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom_range(0, 39) == 0);
      ls = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 9) < 7);
      drive(fs, ls, v, 16'($urandom));
      n_tests++;
      if ({o_Dout_valid, o_Sof, o_Eol, o_Eof, o_Size_err, o_Busy, o_Frame_cnt, o_Dout, o_Pix_x, o_Line_y} !==
          {e_vld, e_sof, e_eol, e_eof, e_err, m_active, m_cnt, e_dout, e_x, e_y}) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_cyc%0d: got vld=%b sof=%b eol=%b eof=%b err=%b busy=%b cnt=%0d dout=%h x=%0d y=%0d, want %b %b %b %b %b %b %0d %h %0d %0d",
                   i, o_Dout_valid, o_Sof, o_Eol, o_Eof, o_Size_err, o_Busy, o_Frame_cnt, o_Dout, o_Pix_x, o_Line_y,
                   e_vld, e_sof, e_eol, e_eof, e_err, m_active, m_cnt, e_dout, e_x, e_y);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_no_frame();
    test_short_line();
    test_early_frame();
    test_back_to_back();
    test_mid_reset();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_pixel_tracker.md
FRAME_PIXEL_TRACKER -- requirements
Module: frame_pixel_tracker

Interface
REQ-001 The block SHALL have parameter IMAGE_WIDTH, default 384, active pixels per line (2..4095).
REQ-002 The block SHALL have parameter IMAGE_HEIGHT, default 288, active lines per frame (2..4095).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1048575, idle-cycle limit inside a frame (only used under FRAME_TIMEOUT_EN).
REQ-004 Port i_Sys_clk, input, 1, SHALL be the single clock; all logic on its rising edge.
REQ-005 Port i_Rst_n, input, 1, SHALL be the reset: synchronous, active-low; clock i_Sys_clk.
REQ-006 Port i_Frame_start, input, 1, SHALL be a one-cycle pulse marking frame start (vsync rising edge from the edge-capture stage).
REQ-007 Port i_Line_start, input, 1, SHALL be a one-cycle pulse marking line start (href rising edge).
REQ-008 Port i_Din_valid, input, 1, SHALL qualify i_Din.
REQ-009 Port i_Din, input, 16, SHALL be raw pixel data.
REQ-010 Ports o_Dout (output, 16) and o_Dout_valid (output, 1) SHALL be the registered pixel and its qualifier.
REQ-011 Ports o_Pix_x (output, 12) and o_Line_y (output, 12) SHALL be the coordinates of the pixel on o_Dout.
REQ-012 Ports o_Sof, o_Eol and o_Eof (outputs, 1 each) SHALL flag, aligned with o_Dout_valid, the first pixel of the frame, the last pixel of a line and the last pixel of the frame.
REQ-013 Port o_Frame_cnt, output, 16, SHALL be the count of completed frames.
REQ-014 Port o_Size_err, output, 1, SHALL be a one-cycle error pulse.
REQ-015 Port o_Busy, output, 1, SHALL be high while the state is ACTIVE.

Function
REQ-016 FSM SHALL have two states, IDLE and ACTIVE; i_Frame_start in IDLE → ACTIVE with x=0, y=0.
REQ-017 In IDLE, i_Din_valid SHALL be ignored: o_Dout_valid stays 0 and no counter moves.
REQ-018 In ACTIVE, each i_Din_valid SHALL produce o_Dout_valid one cycle later (latency 1), carrying the current x/y, then x increments.
REQ-019 At x=IMAGE_WIDTH-1 with i_Din_valid, the block SHALL assert o_Eol, wrap x to 0 and increment y.
REQ-020 At x=IMAGE_WIDTH-1 and y=IMAGE_HEIGHT-1 with i_Din_valid, the block SHALL assert o_Eol and o_Eof, increment o_Frame_cnt (16'hFFFF wraps to 0) and enter IDLE.
REQ-021 o_Sof SHALL be asserted for the pixel at x=0, y=0 only.
REQ-022 i_Line_start in ACTIVE with x≠0 (short line) SHALL pulse o_Size_err, set x=0 and increment y; with x=0 it SHALL have no effect.
REQ-023 i_Frame_start in ACTIVE (early frame) SHALL pulse o_Size_err, leave o_Frame_cnt unchanged and restart at x=0, y=0, staying in ACTIVE.
REQ-024 If i_Frame_start coincides with the final pixel, the frame SHALL complete normally (o_Eof, count+1, no error) and the next frame starts at x=0, y=0 in ACTIVE.
REQ-025 If i_Line_start coincides with a valid pixel, the pixel SHALL be counted first, then the short-line rule is evaluated on the resulting x.
REQ-026 o_Dout SHALL hold its last value when o_Dout_valid=0.

Reset
REQ-027 With i_Rst_n=0 at a clock edge, state SHALL be IDLE and x, y, o_Dout, o_Dout_valid, o_Pix_x, o_Line_y, o_Sof, o_Eol, o_Eof, o_Frame_cnt, o_Size_err, o_Busy and the timeout counter SHALL all be 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no o_Eof or o_Size_err; the next frame requires a new i_Frame_start.

Configuration
REQ-029 With macro FRAME_TIMEOUT_EN defined, a 20-bit counter SHALL count cycles in ACTIVE without i_Din_valid, clear on any valid pixel or on i_Frame_start, and on reaching TIMEOUT_CYC pulse o_Size_err and enter IDLE.
REQ-030 Without FRAME_TIMEOUT_EN, no timeout logic SHALL exist; ACTIVE persists indefinitely and TIMEOUT_CYC is unused.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=2, TIMEOUT_CYC=16)
REQ-031 Frame_start, then 8 valid pixels with data 1..8 → o_Dout 1..8, x 0,1,2,3,0,1,2,3, y 0,0,0,0,1,1,1,1; o_Sof on pixel 1; o_Eol on pixels 4 and 8; o_Eof on pixel 8; o_Frame_cnt=1; o_Busy=0 afterwards.
REQ-032 Valid pixels with no prior Frame_start → o_Dout_valid stays 0 and o_Frame_cnt=0.
REQ-033 Frame_start, 2 pixels, Line_start, 4 pixels → one o_Size_err pulse; the next pixel reports x=0, y=1.
REQ-034 Frame_start, 5 pixels, Frame_start → o_Size_err; o_Frame_cnt unchanged; the next pixel has o_Sof with x=0, y=0.
REQ-035 Final pixel and Frame_start in the same cycle → o_Eof, o_Frame_cnt+1, no o_Size_err, o_Busy stays 1.
REQ-036 FRAME_TIMEOUT_EN defined: Frame_start, 1 pixel, then 16 idle cycles → o_Size_err and o_Busy=0; macro undefined: o_Busy stays 1.
